spi_operand_slave: RTL
======================

Name: spi_operand_slave

Overview:
Parametrised SPI slave that feeds an arithmetic core such as the FP multiplier, generalising the fixed two-operand, 16-bit SPI front end.
- Collects NUM_OPS words of WORD_W bits from the SPI master, MSB first.
- Presents them to the core with a one-cycle valid pulse.
- Accepts the core's result through a valid/ready handshake, then shifts it back out on MISO in a later chip-select frame.
- All SPI pins are oversampled in the clk domain; there is no sck-domain logic.

Parameters:
WORD_W, 16, bits per operand and per result word (IEEE half/bfloat16 default).
NUM_OPS, 2, operand words per transaction (1..8).
SYNC_STAGES, 2, synchroniser flops on sck, mosi and cs (minimum 2).

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-low reset.
sck  input  1  SPI clock, mode 0 (idles low, sample on rise, shift on fall); asynchronous to clk.
mosi  input  1  SPI data in.
cs  input  1  chip select, active low.
miso  output  1  SPI data out.
op_data  output  NUM_OPS*WORD_W  operands; word 0 (first received) in the MS slice.
op_valid  output  1  one-cycle pulse; op_data is valid and stable until the next op_valid.
res_data  input  WORD_W  result from the core.
res_valid  input  1  result offered.
res_ready  output  1  block can accept a result.
busy  output  1  high from op_valid until the result has been fully shifted out.

Behaviour:
Reset values (rst low, asynchronous): miso=0, op_data=0, op_valid=0, res_ready=0, busy=0, state=RX, word/bit counters=0, synchronisers=idle (sck=0, cs=1).

Synchronisation and timing:
- sck, mosi and cs each pass through SYNC_STAGES flops.
- Edges are detected on the synchronised copies.
- Requirement: sck high and low phases each ≥ SYNC_STAGES+2 clk cycles.
- Requirement: ≥ SYNC_STAGES+2 clk cycles between the cs falling edge and the first sck rising edge.

States:
- RX:
  - On each sync sck rise with cs low, shift sync mosi into rx_shift.
  - After WORD_W bits, store the word in slot word_cnt and increment word_cnt.
  - When word_cnt reaches NUM_OPS, drive op_data from the slots, pulse op_valid for 1 cycle, set busy, clear word_cnt, go to WAIT_RES.
  - Latency: op_valid asserts SYNC_STAGES+2 clk cycles after the raw sck rise of the final bit.
- WAIT_RES:
  - res_ready=1.
  - On res_valid&&res_ready, latch res_data into tx_shift, drop res_ready, go to TX_ARM.
  - SPI frames arriving in this state are ignored: mosi is discarded, miso=0, word_cnt is unchanged.
- TX_ARM:
  - Wait for a sync cs fall.
  - On the cs fall, drive miso=tx_shift MSB within 1 clk, go to TX.
- TX:
  - On each sync sck fall, shift tx_shift left and drive the next bit; bit_cnt counts sck rises.
  - After WORD_W rises, clear busy, go to RX.
  - mosi is ignored during TX.

Boundary conditions:
- cs rise mid-word in RX: partial word discarded, bit_cnt=0; completed words are kept. Operands may span frames.
- cs rise mid-TX: abort; result lost, busy cleared, return to RX, miso=0.
- cs high: miso=0, no shifting.
- res_valid outside WAIT_RES: ignored.
- res_valid in the same cycle as op_valid: ignored, because res_ready is still 0 in that cycle.
- Simultaneous sync sck rise and cs rise: the cs rise wins and the bit is discarded.
- Asynchronous reset mid-transaction: all state cleared immediately. The next frame starts at word 0.

Optional Feature:
Macro: SPI_FRAME_ERR_EN.
- Defined:
  - Extra output frame_err (1 bit, reset 0).
  - frame_err is set sticky on any cs rise with bit_cnt≠0 in RX, or on a TX abort.
  - It is cleared by rst, or by the first completed op_valid after it was set (frame_err falls in the cycle after that op_valid).
- Not defined: the port and logic are absent; aborts are silent and behave as described under Behaviour.

Test Plan:
1. Reset with rst=0, then release; one frame with 0x4040, 0x4000 (WORD_W=16, NUM_OPS=2) -> single op_valid pulse, op_data=0x40404000, busy=1, res_ready=1.
2. After scenario 1, drive res_data=0x40C0 with res_valid for one cycle; new cs-low frame with 16 sck -> bench samples miso on sck rise and reads 0x40C0; busy=0 after 16th rise; state back to RX.
3. Send 0x4040 in frame A and 0x4000 in frame B -> op_valid only after frame B, op_data=0x40404000.
4. Send 0x4040 followed by 7 bits, then raise cs; next frame sends 0x3F80, 0x4000 -> op_data=0x40403F80; with SPI_FRAME_ERR_EN, frame_err=1 until that op_valid.
5. Pull rst low mid-way through the second operand, then release; send 0x3F80, 0x3F80 -> op_data=0x3F803F80, with no stale word from before the reset.
6. Parameter sweep WORD_W=32, NUM_OPS=3: send 0x40400000, 0x40000000, 0x3F800000 -> op_data concatenates them in that order; result 0x40C00000 is read back on miso.

Source files
------------

// File: rtl/spi_operand_slave.sv
// spi_operand_slave: oversampled mode-0 SPI slave collecting NUM_OPS operand words and returning one result word.
// Optional sticky frame_err output enabled by defining SPI_FRAME_ERR_EN.
module spi_operand_slave #(
  parameter int WORD_W      = 16,
  parameter int NUM_OPS     = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sck,
  input  logic                        mosi,
  input  logic                        cs,
  output logic                        miso,
  output logic [NUM_OPS*WORD_W-1:0]   op_data,
  output logic                        op_valid,
  input  logic [WORD_W-1:0]           res_data,
  input  logic                        res_valid,
  output logic                        res_ready,
  output logic                        busy
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic                        frame_err
`endif
);
  localparam int BW  = $clog2(WORD_W);
  localparam int WCW = $clog2(NUM_OPS + 1);
  localparam int S   = SYNC_STAGES;

  typedef enum logic [1:0] {RX, WAIT_RES, TX_ARM, TX} state_t;

  state_t state, state_next;
  logic [S:0] sck_p, cs_p;
  logic [S-1:0] mosi_p;
  logic [WORD_W-1:0] rx_shift, tx_shift;
  logic [WORD_W-1:0] slot [NUM_OPS];
  logic [BW-1:0] bit_cnt;
  logic [WCW-1:0] word_cnt;
  logic sck_rise, sck_fall, cs_s, cs_rise, cs_fall, mosi_s, take, last_bit, full;

  // top bit of each pipe is the previous synchronised value, used for edge detection
  assign sck_rise = sck_p[S-1] & ~sck_p[S];
  assign sck_fall = ~sck_p[S-1] & sck_p[S];
  assign cs_s     = cs_p[S-1];
  assign cs_rise  = cs_s & ~cs_p[S];
  assign cs_fall  = ~cs_s & cs_p[S];
  assign mosi_s   = mosi_p[S-1];
  assign take     = res_valid & res_ready;
  assign last_bit = bit_cnt == BW'(WORD_W - 1);
  assign full     = word_cnt == WCW'(NUM_OPS);

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sck_p  <= '0;
      cs_p   <= '1;
      mosi_p <= '0;
    end else begin
      sck_p  <= {sck_p[S-1:0], sck};
      cs_p   <= {cs_p[S-1:0], cs};
      mosi_p <= {mosi_p[S-2:0], mosi};
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= RX;
    else state <= state_next;

  always_comb begin
    state_next = state;
    case (state)
      RX:       state_next = full ? WAIT_RES : RX;
      WAIT_RES: state_next = take ? TX_ARM : WAIT_RES;
      TX_ARM:   state_next = cs_fall ? TX : TX_ARM;
      TX:       state_next = (cs_rise || (sck_rise && last_bit)) ? RX : TX;
      default:  state_next = RX;
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      miso      <= 1'b0;
      op_data   <= '0;
      op_valid  <= 1'b0;
      res_ready <= 1'b0;
      busy      <= 1'b0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      for (int i = 0; i < NUM_OPS; i++) slot[i] <= '0;
    end else begin
      op_valid  <= 1'b0;
      res_ready <= state == WAIT_RES && !take;
      case (state)
        RX:
          if (full) begin
            for (int i = 0; i < NUM_OPS; i++) op_data[(NUM_OPS-1-i)*WORD_W +: WORD_W] <= slot[i];
            op_valid <= 1'b1;
            busy     <= 1'b1;
            word_cnt <= '0;
            bit_cnt  <= '0;
          end else if (cs_rise) bit_cnt <= '0;
          else if (sck_rise && !cs_s) begin
            rx_shift <= {rx_shift[WORD_W-2:0], mosi_s};
            bit_cnt  <= last_bit ? '0 : bit_cnt + 1'b1;
            if (last_bit) begin
              for (int i = 0; i < NUM_OPS; i++)
                if (word_cnt == WCW'(i)) slot[i] <= {rx_shift[WORD_W-2:0], mosi_s};
              word_cnt <= word_cnt + 1'b1;
            end
          end
        WAIT_RES: if (take) tx_shift <= res_data;
        TX_ARM:   if (cs_fall) miso <= tx_shift[WORD_W-1];
        TX:
          if (cs_rise || (sck_rise && last_bit)) begin
            miso    <= 1'b0;
            busy    <= 1'b0;
            bit_cnt <= '0;
          end else begin
            if (sck_rise) bit_cnt <= bit_cnt + 1'b1;
            if (sck_fall) begin
              tx_shift <= tx_shift << 1;
              miso     <= tx_shift[WORD_W-2];
            end
          end
        default: miso <= 1'b0;
      endcase
    end

`ifdef SPI_FRAME_ERR_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) frame_err <= 1'b0;
    else if ((state == RX && !full && cs_rise && bit_cnt != '0) || (state == TX && cs_rise)) frame_err <= 1'b1;
    else if (op_valid) frame_err <= 1'b0;
`endif
endmodule
